// File: rtl/ser_sub_unit.sv
// Bit-serial two's-complement subtractor (Diff = A - B), LSB first, one full-subtractor
// cell plus a borrow flop, sequenced by a start/busy/done handshake.
module ser_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic [CW-1:0]    count_r;
  logic             borrow_r;
  logic             a_msb_r;
  logic             b_msb_r;

  logic             d_s;
  logic             borrow_next_s;
  logic             last_s;

  function automatic logic fs_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  // Full-subtractor cell on the current LSBs and last-bit detect.
  always_comb begin
    d_s           = fs_diff(sa_r[0], sb_r[0], borrow_r);
    borrow_next_s = fs_borrow(sa_r[0], sb_r[0], borrow_r);
    last_s        = (count_r == LAST);
  end

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      sa_r     <= '0;
      sb_r     <= '0;
      res_r    <= '0;
      count_r  <= '0;
      borrow_r <= 1'b0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      Diff     <= '0;
      Bout     <= 1'b0;
      V        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_r     <= A;
            sb_r     <= B;
            a_msb_r  <= A[WIDTH-1];
            b_msb_r  <= B[WIDTH-1];
            borrow_r <= 1'b0;
            count_r  <= '0;
            busy     <= 1'b1;
            state_r  <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          res_r    <= {d_s, res_r[WIDTH-1:1]};
          sa_r     <= {1'b0, sa_r[WIDTH-1:1]};
          sb_r     <= {1'b0, sb_r[WIDTH-1:1]};
          borrow_r <= borrow_next_s;
          count_r  <= count_r + 1'b1;
          if (last_s) begin
            // The final bit goes straight to Diff; res_r alone would lag by one edge.
            Diff    <= {d_s, res_r[WIDTH-1:1]};
            Bout    <= borrow_next_s;
            V       <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= SHIFT;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_sub_unit.sv
// Self-checking bench for ser_sub_unit (WIDTH=8): directed table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
module tb_ser_sub_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Diff;
  logic       Bout;
  logic       V;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       v;
  } vec_t;

  vec_t tbl [8];

  ser_sub_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Diff  (Diff),
    .Bout  (Bout),
    .V     (V),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, unsigned compare, signed range test.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] d, output logic bo, output logic v);
    int ua;
    int ub;
    int sdiff;
    ua    = int'(a);
    ub    = int'(b);
    d     = 8'((ua - ub + 256) % 256);
    bo    = (ua < ub);
    sdiff = int'($signed(a)) - int'($signed(b));
    v     = (sdiff > 127) || (sdiff < -128);
  endtask

  // Launch one op from IDLE and wait for done; optionally pulse a stray start mid-op.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit inject,
                        output logic [7:0] d, output logic bo, output logic v, output int lat);
    bit busy_bad;
    busy_bad = 1'b0;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 30) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (inject && lat == 3) begin
        start = 1'b1;
        A = 8'h01;
        B = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("busy_during_shift", 32'(busy_bad), 32'd0);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    d  = Diff;
    bo = Bout;
    v  = V;
  endtask

  task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb, input logic ev, input bit inject);
    logic [7:0] d;
    logic       bo;
    logic       v;
    int         lat;
    run_op(a, b, inject, d, bo, v, lat);
    chk({name, "_latency"}, 32'(lat), 32'd9);
    chk({name, "_diff"}, 32'(d), 32'(ed));
    chk({name, "_bout"}, 32'(bo), 32'(eb));
    chk({name, "_v"}, 32'(v), 32'(ev));
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [7:0] md;
    logic       mb;
    logic       mv;
    int         done_t [$];
    int         cyc;

    tbl[0] = '{8'h3A, 8'h2A, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'h2A, 8'h3A, 8'hF0, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
    tbl[7] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    #20;
    reset = 1'b0;
    chk("reset_diff", 32'(Diff), 32'd0);
    chk("reset_bout", 32'(Bout), 32'd0);
    chk("reset_v", 32'(V), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      check_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].bout, tbl[i].v, 1'b0);
    end

    // Reset four edges into SHIFT aborts with all outputs cleared and no done.
    @(negedge clk);
    A = 8'h3A;
    B = 8'h2A;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(Diff), 32'd0);
    chk("abort_bout", 32'(Bout), 32'd0);
    chk("abort_v", 32'(V), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_no_done("abort_no_done", 12);
    check_op("after_abort", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);

    // Stray start while busy is ignored; exactly one done for the op.
    check_op("ignore_start", 8'h2A, 8'h3A, 8'hF0, 1'b1, 1'b0, 1'b1);
    expect_no_done("ignore_single_done", 12);

    // start held high: back-to-back ops every WIDTH+2 cycles.
    @(negedge clk);
    A = 8'h05;
    B = 8'h03;
    start = 1'b1;
    cyc = 0;
    while (done_t.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        done_t.push_back(cyc);
        chk("b2b_diff", 32'(Diff), 32'h02);
        if (done_t.size() == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(done_t.size()), 32'd3);
    if (done_t.size() == 3) begin
      chk("b2b_spacing1", 32'(done_t[1] - done_t[0]), 32'd10);
      chk("b2b_spacing2", 32'(done_t[2] - done_t[1]), 32'd10);
    end
    expect_no_done("b2b_stop", 12);

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      model(ra, rb, md, mb, mv);
      check_op("rand", ra, rb, md, mb, mv, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
